// File: rtl/tt_pkg.sv
// Shared types and constants for the truth-table sweep/capture stage.
package tt_pkg;

  typedef enum logic [1:0] {IDLE, APPLY, EMIT, FIN} tt_state_e;

  localparam int unsigned TT_IDX_W = 6;
  localparam logic [31:0] CRC_POLY = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;

  // Truth-table width for an n-input circuit.
  function automatic int unsigned tt_w(input int unsigned n);
    return 32'd1 << n;
  endfunction

endpackage

// File: rtl/tt_misr.sv
// CRC32 MISR: folds one zero-extended truth-table word per enable, MSB first,
// as a single-cycle equivalent of 32 serial Galois steps.
module tt_misr
  import tt_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          en,
  input  logic [DW-1:0] data,
  output logic [31:0]   sig
);

  logic [31:0] data_z;
  logic [31:0] sig_nxt;
  logic        fb;

  assign data_z = 32'(data);

  always_comb begin
    sig_nxt = sig;
    fb      = 1'b0;
    for (int b = 31; b >= 0; b--) begin
      fb      = sig_nxt[31] ^ data_z[b];
      sig_nxt = {sig_nxt[30:0], 1'b0} ^ (fb ? CRC_POLY : 32'h0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    sig <= CRC_INIT;
    else if (load) sig <= CRC_INIT;
    else if (en)   sig <= sig_nxt;
  end

endmodule

// File: rtl/tt_sweep_capture.sv
// Exhaustive sweep of a combinational circuit, streaming one truth-table word
// per output. Optional CRC32 signature output enabled by TT_SIGNATURE_EN.
module tt_sweep_capture
  import tt_pkg::*;
#(
  parameter int N_IN   = 4,
  parameter int N_OUT  = 12,
  parameter int SETTLE = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic [N_IN-1:0]         dut_x,
  input  logic [N_OUT-1:0]        dut_f,
  output logic                    tt_valid,
  input  logic                    tt_ready,
  output logic [TT_IDX_W-1:0]     tt_idx,
  output logic [tt_w(N_IN)-1:0]   tt_data,
`ifdef TT_SIGNATURE_EN
  output logic [31:0]             sig,
`endif
  output tt_state_e               dbg_state
);

  localparam int                   TW       = tt_w(N_IN);
  localparam int                   CNT_W    = 4;
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(SETTLE);
  localparam logic [N_IN-1:0]      PAT_LAST = '1;
  localparam logic [TT_IDX_W-1:0]  K_LAST   = TT_IDX_W'(N_OUT - 1);

  tt_state_e             state, state_nx;
  logic [CNT_W-1:0]      cnt;
  logic [TT_IDX_W-1:0]   k;
  logic [TW-1:0]         cap [N_OUT];
  logic                  sample, last_pat, hs, last_word;

  // Stream handshake: a word transfers on a rising edge where tt_valid and
  // tt_ready are both high; while tt_ready is low the word is held unchanged.
  assign sample    = (state == APPLY) && (cnt == CNT_LAST);
  assign last_pat  = (dut_x == PAT_LAST);
  assign hs        = (state == EMIT) && tt_ready;
  assign last_word = (k == K_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = APPLY;
      APPLY:   if (sample && last_pat) state_nx = EMIT;
      EMIT:    if (hs && last_word) state_nx = FIN;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == APPLY) || (state == EMIT);
    done      = (state == FIN);
    tt_valid  = (state == EMIT);
    tt_idx    = k;
    dbg_state = state;
    tt_data   = '0;
    for (int j = 0; j < N_OUT; j++) begin
      if ((state == EMIT) && (k == TT_IDX_W'(j))) tt_data = cap[j];
    end
  end

  // dut_x doubles as the pattern counter, so it holds the last pattern after the sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      k     <= '0;
      dut_x <= '0;
      for (int j = 0; j < N_OUT; j++) cap[j] <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          cnt   <= '0;
          k     <= '0;
          dut_x <= '0;
        end
        APPLY: begin
          if (sample) begin
            for (int j = 0; j < N_OUT; j++) cap[j][dut_x] <= dut_f[j];
            cnt <= '0;
            k   <= '0;
            if (!last_pat) dut_x <= dut_x + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        EMIT: if (hs && !last_word) k <= k + 1'b1;
        default: ;
      endcase
    end
  end

`ifdef TT_SIGNATURE_EN
  tt_misr #(.DW(TW)) u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  ((state == IDLE) && start),
    .en    (hs),
    .data  (tt_data),
    .sig   (sig)
  );
`endif

endmodule
